// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V core: default widths, the flush NOP and
// the fetch-controller state encoding.
package riscv_pkg;
    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    localparam logic [1:0] FS_REQ  = 2'd0;
    localparam logic [1:0] FS_WAIT = 2'd1;
    localparam logic [1:0] FS_HOLD = 2'd2;
    localparam logic [1:0] FS_DROP = 2'd3;
endpackage

// File: rtl/fetch_ctrl_fsm.sv
// Fetch sequencing: one outstanding instruction-memory request, stall hold
// buffer control and redirect flush/drop handling.
//
//   state   | meaning
//   FS_REQ  | request presented at pc, waiting for grant
//   FS_WAIT | request granted, waiting for read data
//   FS_HOLD | data captured in hold buffer while IF/ID is stalled
//   FS_DROP | redirected while a request is outstanding; discard its data
module fetch_ctrl_fsm
    import riscv_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic redirect,
    input  logic imem_gnt,
    input  logic imem_rvalid,
    output logic imem_req,
    output logic deliver,
    output logic deliver_buf,
    output logic flush,
    output logic take_inflight,
    output logic take_buf
);

    logic [1:0] state_q;
    logic [1:0] state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FS_REQ;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            case (state_q)
                FS_REQ:  state_d = imem_gnt    ? FS_DROP : FS_REQ;
                FS_WAIT: state_d = imem_rvalid ? FS_REQ  : FS_DROP;
                FS_HOLD: state_d = FS_REQ;
                default: state_d = imem_rvalid ? FS_REQ  : FS_DROP;
            endcase
        end else begin
            case (state_q)
                FS_REQ:  state_d = imem_gnt ? FS_WAIT : FS_REQ;
                FS_WAIT: if (imem_rvalid) state_d = stall ? FS_HOLD : FS_REQ;
                FS_HOLD: state_d = stall ? FS_HOLD : FS_REQ;
                default: state_d = imem_rvalid ? FS_REQ : FS_DROP;
            endcase
        end
    end

    // Everything is masked while reset is high so nothing leaves the stage.
    always_comb begin
        imem_req      = 1'b0;
        deliver       = 1'b0;
        deliver_buf   = 1'b0;
        flush         = 1'b0;
        take_inflight = 1'b0;
        take_buf      = 1'b0;
        if (!reset) begin
            flush = redirect;
            case (state_q)
                FS_REQ: begin
                    imem_req      = 1'b1;
                    take_inflight = imem_gnt;
                end
                FS_WAIT: begin
                    if (imem_rvalid && !redirect) begin
                        take_buf = stall;
                        deliver  = !stall;
                    end
                end
                FS_HOLD: begin
                    deliver     = !stall && !redirect;
                    deliver_buf = !stall && !redirect;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, the in-flight request PC and the
// stall hold buffer, and drives the IF/ID register load.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int          XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_id_load,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_q;
    logic [31:0]     buf_q;
    logic            deliver;
    logic            deliver_buf;
    logic            flush;
    logic            take_inflight;
    logic            take_buf;

    fetch_ctrl_fsm u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_req     (imem_req),
        .deliver      (deliver),
        .deliver_buf  (deliver_buf),
        .flush        (flush),
        .take_inflight(take_inflight),
        .take_buf     (take_buf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            buf_q      <= '0;
        end else begin
            if (redirect)     pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (deliver) pc_q <= inflight_q + XLEN'(4);
            if (take_inflight) inflight_q <= pc_q;
            if (take_buf)      buf_q      <= imem_rdata;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_load  = deliver | flush;
    assign if_id_valid = deliver;
    assign if_id_pc    = deliver ? inflight_q : '0;
    assign if_id_instr = deliver ? (deliver_buf ? buf_q : imem_rdata) : NOP;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hand-driven memory handshake, stall hold,
// redirect flush/drop, PC wrap and mid-transaction reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_id_load;
    logic [31:0] if_id_pc, if_id_instr;
    logic        if_id_valid;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOPW = 32'h0000_0013;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_id_load (if_id_load),
        .if_id_pc   (if_id_pc),
        .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next edge, apply inputs, let comb settle.
    task automatic drive(input logic rst, input logic stl, input logic rdr,
                         input logic [31:0] rpc, input logic gnt,
                         input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc;
        imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
        #1;
    endtask

    task automatic chk_deliver(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_load"},  32'(if_id_load),  32'd1);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd1);
        chk({tag, "_pc"},    if_id_pc,         pc);
        chk({tag, "_instr"}, if_id_instr,      ins);
    endtask

    task automatic chk_flush(input string tag);
        chk({tag, "_load"},  32'(if_id_load),  32'd1);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, "_instr"}, if_id_instr,      NOPW);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        #2;
        chk("rst_req",   32'(imem_req),   32'd0);
        chk("rst_load",  32'(if_id_load), 32'd0);
        chk("rst_valid", 32'(if_id_valid),32'd0);
        chk("rst_instr", if_id_instr,     NOPW);
        chk("rst_pc",    if_id_pc,        32'd0);
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("rst_req_gnt", 32'(imem_req), 32'd0);

        // Streaming fetch with single-cycle memory
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("f0_req",  32'(imem_req), 32'd1);
        chk("f0_addr", imem_addr,     32'h0);
        chk("f0_noload", 32'(if_id_load), 32'd0);
        drive(0, 0, 0, 0, 0, 1, 32'h1000_0000);
        chk("f0_reqlow", 32'(imem_req), 32'd0);
        chk_deliver("d0", 32'h0, 32'h1000_0000);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("f1_addr", imem_addr, 32'h4);
        drive(0, 0, 0, 0, 0, 1, 32'h1000_0004);
        chk_deliver("d1", 32'h4, 32'h1000_0004);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("f2_addr", imem_addr, 32'h8);
        drive(0, 0, 0, 0, 0, 1, 32'h1000_0008);
        chk_deliver("d2", 32'h8, 32'h1000_0008);

        // Response arrives under a three-cycle stall
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("f3_addr", imem_addr, 32'hC);
        drive(0, 1, 0, 0, 0, 1, 32'h1000_000C);
        chk("st0_load", 32'(if_id_load), 32'd0);
        drive(0, 1, 0, 0, 0, 0, 32'hBAD0_0000);
        chk("st1_load", 32'(if_id_load), 32'd0);
        chk("st1_req",  32'(imem_req),   32'd0);
        drive(0, 1, 0, 0, 0, 0, 32'hBAD0_0000);
        chk("st2_load", 32'(if_id_load), 32'd0);
        chk("st2_req",  32'(imem_req),   32'd0);
        drive(0, 0, 0, 0, 0, 0, 32'hBAD0_0000);
        chk_deliver("hold", 32'hC, 32'h1000_000C);

        // Redirect while waiting: flush, then drop the stale response
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("f4_addr", imem_addr, 32'h10);
        drive(0, 0, 1, 32'h100, 0, 0, 0);
        chk_flush("rdw");
        drive(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("drop_load", 32'(if_id_load), 32'd0);
        chk("drop_req",  32'(imem_req),   32'd0);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("rd_req",  32'(imem_req), 32'd1);
        chk("rd_addr", imem_addr,     32'h100);

        // Redirect coincident with rvalid under stall; low address bits ignored
        drive(0, 1, 1, 32'h103, 0, 1, 32'h5555_5555);
        chk_flush("rdv");
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rdv_req",  32'(imem_req), 32'd1);
        chk("rdv_addr", imem_addr,     32'h100);
        chk("rdv_noload", 32'(if_id_load), 32'd0);

        // PC wrap from the top of the address space
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        chk_flush("rdr");
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 1, 32'h2222_2222);
        chk_deliver("wrap", 32'hFFFF_FFFC, 32'h2222_2222);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset in the middle of an outstanding fetch
        drive(0, 0, 0, 0, 0, 1, 32'h3333_3333);
        chk_deliver("pre_rst", 32'h0, 32'h3333_3333);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("pre_rst_addr", imem_addr, 32'h4);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("mr_req",  32'(imem_req),   32'd0);
        chk("mr_load", 32'(if_id_load), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("mr_rel_req",  32'(imem_req), 32'd1);
        chk("mr_rel_addr", imem_addr,     32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
